slv_guard_rst_ctrl: RTL and testbench
=====================================

# slv_guard_rst_ctrl

Reset sequencer directly downstream of the subordinate guard. It consumes the guard's reset request and drives the subordinate's reset through a fixed sequence: isolate, assert, recover, clear. Once the sequence completes it returns the reset-status pulse that clears the guard. It retries when the guard does not release, and latches a failure after a bounded number of retries.

## Interface
- `IsolateCycles`, default 4: cycles bus is held isolated before reset asserts; ≥1.
- `HoldCycles`, default 16: cycles subordinate reset is held low; ≥1.
- `RecoverCycles`, default 8: cycles after reset release before status is reported; ≥1.
- `MaxRetries`, default 3: extra assert sequences attempted before FAIL; ≥0.
- `CntWidth`, default 8: width of the reset event counter.
- Any zero-valued cycle parameter is an elaboration error.

- `clk_i`  in  1  clock; the only clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `enable_i`  in  1  guard enable; requests are ignored in IDLE while low.
- `rst_req_i`  in  1  reset request from guard (`reset_req_o`), level.
- `sw_clr_i`  in  1  single-cycle software clear from register file.
- `slv_rst_no`  out  1  active-low reset to guarded subordinate.
- `isolate_o`  out  1  bus isolation request to guard/crossbar.
- `rst_stat_o`  out  1  reset-done status to guard (`reset_clear_i`).
- `busy_o`  out  1  sequencer not in IDLE.
- `fail_o`  out  1  retries exhausted, latched.
- `rst_cnt_o`  out  CntWidth  number of ASSERT entries, saturating.

## Operation
- FSM states: IDLE, ISOLATE, ASSERT, RECOVER, CLEAR, FAIL.
- A single down-counter, width $clog2(max(IsolateCycles, HoldCycles, RecoverCycles)+1), times ISOLATE, ASSERT and RECOVER.
  - Each state loads its count on entry.
  - Each state exits when the count reaches 1.
- A retry counter, width $clog2(MaxRetries+1) (min 1), is cleared on IDLE→ISOLATE.
- Transitions:
  - IDLE→ISOLATE: `rst_req_i && enable_i`.
  - ISOLATE→ASSERT: after IsolateCycles.
  - ASSERT→RECOVER: after HoldCycles.
  - RECOVER→CLEAR: after RecoverCycles.
  - CLEAR: lasts exactly 2 cycles. At its end:
    - `rst_req_i`=0 → IDLE.
    - else retry_cnt<MaxRetries → retry_cnt++, ASSERT.
    - else → FAIL.
  - FAIL→IDLE: only on `sw_clr_i`.
- Outputs are decoded from the state register (Moore):
  - `isolate_o`=1 in every state except IDLE.
  - `slv_rst_no`=0 in ASSERT, otherwise 1, gated by `rst_ni`.
  - `rst_stat_o`=1 in both CLEAR cycles.
  - `busy_o`=(state≠IDLE).
  - `fail_o`=(state==FAIL).
- `rst_cnt_o` increments on every entry into ASSERT, including retries, and saturates at all-ones.
- `sw_clr_i` zeroes `rst_cnt_o` in any state; clear wins over a simultaneous increment.
- `enable_i` is only sampled in IDLE. Deasserting it mid-sequence does not abort the sequence.
- `rst_req_i` is only sampled in IDLE and at the end of CLEAR. Glitches elsewhere are ignored.

## Timing
- Reset values: state=IDLE, `slv_rst_no`=0 while `rst_ni` low (combinational AND) and 1 after release, all other outputs 0, counters 0.
- With `rst_req_i` first sampled high at edge k (in IDLE):
  - ISOLATE occupies cycles k+1..k+I.
  - ASSERT occupies k+I+1..k+I+H.
  - RECOVER occupies the next R cycles.
  - CLEAR occupies the next 2 cycles.
  - I=IsolateCycles, H=HoldCycles, R=RecoverCycles.
- Minimum request-to-status latency: I+H+R+1 cycles. A retry re-enters ASSERT the cycle after CLEAR.
- Async reset mid-sequence: all outputs take reset values immediately, and the FSM restarts in IDLE.
- `rst_req_i` held high while returning to IDLE: a new sequence starts on the next cycle if `enable_i`=1.

## Test plan
Configuration for all scenarios: I=2, H=4, R=3, MaxRetries=2, CntWidth=8.
- **Nominal sequence.** Stimulus: `rst_req_i` rises at cycle 10 and drops at cycle 21. Required response:
  - `isolate_o`=1 over cycles 11–21.
  - `slv_rst_no`=0 over cycles 13–16.
  - `rst_stat_o`=1 over cycles 20–21.
  - IDLE at cycle 22, `rst_cnt_o`=1.
- **Stuck request.** Stimulus: `rst_req_i` stays high. Required response:
  - Three `slv_rst_no` low windows of 4 cycles each.
  - Then FAIL, `fail_o`=1, `isolate_o`=1, `rst_cnt_o`=3.
  - Then `sw_clr_i` → IDLE, `rst_cnt_o`=0, `fail_o`=0.
- **Disabled.** Stimulus: `enable_i`=0 and `rst_req_i`=1 for 50 cycles. Required response: `busy_o`=0, `slv_rst_no`=1, `rst_cnt_o`=0 throughout.
- **Async reset mid-sequence.** Stimulus: `rst_ni` pulled low in the 2nd ASSERT cycle. Required response:
  - `slv_rst_no`=0, `isolate_o`=0, `busy_o`=0 without waiting for a clock edge.
  - After release: IDLE and `rst_cnt_o`=0.
- **Saturation and clear priority.** Stimulus: `rst_cnt_o` preloaded to 255 via repeated stuck sequences, then `sw_clr_i` coincident with an ASSERT entry. Required response: `rst_cnt_o` stays 255 on further entries, and reads 0 after the coincident clear.
- **Release in 1st CLEAR cycle.** Stimulus: `rst_req_i` drops in the first CLEAR cycle. Required response: IDLE after exactly 2 CLEAR cycles, no retry.

Source files
------------

// File: rtl/slv_guard_rst_ctrl.sv
// slv_guard_rst_ctrl: subordinate reset sequencer (isolate, assert, recover, clear) with bounded retry
module slv_guard_rst_ctrl #(
    parameter int unsigned IsolateCycles = 4,
    parameter int unsigned HoldCycles    = 16,
    parameter int unsigned RecoverCycles = 8,
    parameter int unsigned MaxRetries    = 3,
    parameter int unsigned CntWidth      = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                rst_req_i,
    input  logic                sw_clr_i,
    output logic                slv_rst_no,
    output logic                isolate_o,
    output logic                rst_stat_o,
    output logic                busy_o,
    output logic                fail_o,
    output logic [CntWidth-1:0] rst_cnt_o
);
    localparam int unsigned MaxIh  = (IsolateCycles > HoldCycles) ? IsolateCycles : HoldCycles;
    localparam int unsigned MaxCyc = (MaxIh > RecoverCycles) ? MaxIh : RecoverCycles;
    localparam int unsigned TW     = $clog2(MaxCyc + 1);
    localparam int unsigned RW     = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

    if (IsolateCycles == 0 || HoldCycles == 0 || RecoverCycles == 0) begin : g_bad_cfg
        $error("slv_guard_rst_ctrl: cycle parameters must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, ISOLATE, ASSERT, RECOVER, CLEAR, FAIL} state_t;

    state_t        state;
    logic [TW-1:0] tmr;
    logic [RW-1:0] retry;
    logic          clr_last;
    logic [4:0]    outs_q;
    logic          last;
    logic          retry_ok;
    logic          enter_assert;

    // output vector {isolate, slv_rst_n, rst_stat, busy, fail} for a given state
    function automatic logic [4:0] decode(input state_t s);
        return {s != IDLE, s != ASSERT, s == CLEAR, s != IDLE, s == FAIL};
    endfunction

    assign last         = tmr == TW'(1);
    assign retry_ok     = retry < RW'(MaxRetries);
    assign enter_assert = (state == ISOLATE && last) ||
                          (state == CLEAR && clr_last && rst_req_i && retry_ok);

    assign isolate_o  = outs_q[4];
    assign slv_rst_no = outs_q[3] & rst_ni;
    assign rst_stat_o = outs_q[2];
    assign busy_o     = outs_q[1];
    assign fail_o     = outs_q[0];

    // sequencer: shared down-counter times each phase, outputs registered alongside the state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            tmr      <= '0;
            retry    <= '0;
            clr_last <= 1'b0;
            outs_q   <= decode(IDLE);
        end else begin
            case (state)
                IDLE: if (rst_req_i && enable_i) begin
                    state  <= ISOLATE;
                    tmr    <= TW'(IsolateCycles);
                    retry  <= '0;
                    outs_q <= decode(ISOLATE);
                end
                ISOLATE: if (last) begin
                    state  <= ASSERT;
                    tmr    <= TW'(HoldCycles);
                    outs_q <= decode(ASSERT);
                end else begin
                    tmr <= tmr - TW'(1);
                end
                ASSERT: if (last) begin
                    state  <= RECOVER;
                    tmr    <= TW'(RecoverCycles);
                    outs_q <= decode(RECOVER);
                end else begin
                    tmr <= tmr - TW'(1);
                end
                RECOVER: if (last) begin
                    state    <= CLEAR;
                    clr_last <= 1'b0;
                    outs_q   <= decode(CLEAR);
                end else begin
                    tmr <= tmr - TW'(1);
                end
                CLEAR: if (!clr_last) begin
                    clr_last <= 1'b1;
                end else if (!rst_req_i) begin
                    state  <= IDLE;
                    outs_q <= decode(IDLE);
                end else if (retry_ok) begin
                    state  <= ASSERT;
                    retry  <= retry + RW'(1);
                    tmr    <= TW'(HoldCycles);
                    outs_q <= decode(ASSERT);
                end else begin
                    state  <= FAIL;
                    outs_q <= decode(FAIL);
                end
                FAIL: if (sw_clr_i) begin
                    state  <= IDLE;
                    outs_q <= decode(IDLE);
                end
                default: begin
                    state  <= IDLE;
                    outs_q <= decode(IDLE);
                end
            endcase
        end
    end

    // reset event counter: counts ASSERT entries, saturates, software clear has priority
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_cnt_o <= '0;
        end else if (sw_clr_i) begin
            rst_cnt_o <= '0;
        end else if (enter_assert && !(&rst_cnt_o)) begin
            rst_cnt_o <= rst_cnt_o + CntWidth'(1);
        end
    end
endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// tb_slv_guard_rst_ctrl: scoreboard bench for the reset sequencer (I=2, H=4, R=3, MaxRetries=2)
module tb_slv_guard_rst_ctrl;
    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       enable_i = 1'b1;
    logic       rst_req_i = 1'b0;
    logic       sw_clr_i = 1'b0;
    logic       slv_rst_no;
    logic       isolate_o;
    logic       rst_stat_o;
    logic       busy_o;
    logic       fail_o;
    logic [7:0] rst_cnt_o;

    // phase vectors {isolate, slv_rst_n, rst_stat, busy, fail}
    localparam logic [4:0] P_RST  = 5'b00000;
    localparam logic [4:0] P_IDLE = 5'b01000;
    localparam logic [4:0] P_ISO  = 5'b11010;
    localparam logic [4:0] P_ASS  = 5'b10010;
    localparam logic [4:0] P_REC  = 5'b11010;
    localparam logic [4:0] P_CLR  = 5'b11110;
    localparam logic [4:0] P_FAIL = 5'b11011;

    typedef struct {
        int          cyc;
        string       tag;
        logic [12:0] exp;
    } chk_t;

    chk_t        q[$];
    chk_t        e;
    logic [12:0] act;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    slv_guard_rst_ctrl #(
        .IsolateCycles(2),
        .HoldCycles(4),
        .RecoverCycles(3),
        .MaxRetries(2),
        .CntWidth(8)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .enable_i(enable_i),
        .rst_req_i(rst_req_i),
        .sw_clr_i(sw_clr_i),
        .slv_rst_no(slv_rst_no),
        .isolate_o(isolate_o),
        .rst_stat_o(rst_stat_o),
        .busy_o(busy_o),
        .fail_o(fail_o),
        .rst_cnt_o(rst_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic push(int c, string tag, logic [4:0] ph, int cnt);
        chk_t n;
        n.cyc = c;
        n.tag = tag;
        n.exp = {ph, 8'(cnt)};
        q.push_back(n);
    endtask

    task automatic span(int a, int b, string tag, logic [4:0] ph, int cnt);
        for (int c = a; c <= b; c++) push(c, tag, ph, cnt);
    endtask

    // expected timeline of one request starting in cycle s with n assert windows
    task automatic seq_exp(int s, int n, int c0, bit clr_first, string tag);
        int a;
        int c;
        span(s + 1, s + 2, tag, P_ISO, c0);
        for (int i = 0; i < n; i++) begin
            a = s + 3 + 9 * i;
            c = clr_first ? i : ((c0 + i + 1 > 255) ? 255 : c0 + i + 1);
            span(a, a + 3, tag, P_ASS, c);
            span(a + 4, a + 6, tag, P_REC, c);
            span(a + 7, a + 8, tag, P_CLR, c);
        end
    endtask

    task automatic at(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk(string tag, logic [7:0] got, logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // monitor: sample just after each rising edge and retire expectations due this cycle
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                act = {isolate_o, slv_rst_no, rst_stat_o, busy_o, fail_o, rst_cnt_o};
                checks++;
                if (e.cyc != cyc || act !== e.exp) begin
                    errors++;
                    $display("FAIL %s cyc %0d: got %h want %h", e.tag, e.cyc, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        span(1, 2, "reset", P_RST, 0);
        span(3, 10, "idle0", P_IDLE, 0);
        at(2);
        rst_ni = 1'b1;
        at(10);
        rst_req_i = 1'b1;
        seq_exp(10, 1, 0, 1'b0, "nominal");
        span(22, 26, "nom_idle", P_IDLE, 1);
        at(21);
        rst_req_i = 1'b0;
        at(26);
        sw_clr_i = 1'b1;
        span(27, 29, "clr_idle", P_IDLE, 0);
        at(27);
        sw_clr_i = 1'b0;
        at(30);
        rst_req_i = 1'b1;
        seq_exp(30, 3, 0, 1'b0, "stuck");
        span(60, 64, "fail", P_FAIL, 3);
        span(65, 68, "fail_clr", P_IDLE, 0);
        at(64);
        sw_clr_i = 1'b1;
        rst_req_i = 1'b0;
        at(65);
        sw_clr_i = 1'b0;
        at(69);
        enable_i = 1'b0;
        span(70, 125, "disabled", P_IDLE, 0);
        at(70);
        rst_req_i = 1'b1;
        at(120);
        rst_req_i = 1'b0;
        at(121);
        enable_i = 1'b1;
        at(130);
        rst_req_i = 1'b1;
        span(131, 132, "async_iso", P_ISO, 0);
        span(133, 134, "async_assert", P_ASS, 1);
        span(135, 136, "async_rst", P_RST, 0);
        span(137, 139, "async_idle", P_IDLE, 0);
        at(131);
        enable_i = 1'b0;
        at(134);
        rst_ni = 1'b0;
        rst_req_i = 1'b0;
        #1;
        chk("async_slv_rst_n", 8'(slv_rst_no), 8'd0);
        chk("async_isolate", 8'(isolate_o), 8'd0);
        chk("async_busy", 8'(busy_o), 8'd0);
        chk("async_cnt", rst_cnt_o, 8'd0);
        at(136);
        rst_ni = 1'b1;
        enable_i = 1'b1;
        at(140);
        rst_req_i = 1'b1;
        seq_exp(140, 1, 0, 1'b0, "early");
        span(152, 155, "early_idle", P_IDLE, 1);
        at(150);
        rst_req_i = 1'b0;
        at(155);
        sw_clr_i = 1'b1;
        span(156, 159, "sat_clr", P_IDLE, 0);
        at(156);
        sw_clr_i = 1'b0;
        for (int k = 0; k < 85; k++) begin
            s = 160 + 30 * k;
            at(s);
            rst_req_i = 1'b1;
            push(s + 3, "sat_assert", P_ASS, 3 * k + 1);
            push(s + 29, "sat_clear", P_CLR, 3 * k + 3);
            push(s + 30, "sat_idle", P_IDLE, 3 * k + 3);
            at(s + 29);
            rst_req_i = 1'b0;
        end
        at(2710);
        rst_req_i = 1'b1;
        seq_exp(2710, 3, 255, 1'b0, "sat_hold");
        push(2740, "sat_hold_idle", P_IDLE, 255);
        at(2739);
        rst_req_i = 1'b0;
        at(2740);
        rst_req_i = 1'b1;
        seq_exp(2740, 3, 255, 1'b1, "coinc_clr");
        span(2770, 2772, "coinc_idle", P_IDLE, 2);
        at(2742);
        sw_clr_i = 1'b1;
        at(2743);
        sw_clr_i = 1'b0;
        at(2769);
        rst_req_i = 1'b0;
        at(2775);
        if (q.size() > 0) begin
            errors += q.size();
            $display("FAIL leftover: got %0d unchecked want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
